// File: rtl/fp_exc_pkg.sv
// Shared status encoding and default widths for the FP exception checker.
package fp_exc_pkg;

  localparam int unsigned EW_DEF = 5;
  localparam int unsigned MW_DEF = 10;
  localparam int unsigned CW_DEF = 8;

  typedef enum logic [1:0] {
    ST_ZERO = 2'b00,
    ST_OVF  = 2'b01,
    ST_UNF  = 2'b10,
    ST_NORM = 2'b11
  } status_e;

endpackage

// File: rtl/fp_exc_classify.sv
// Combinational classification of an unchecked FP result into zero/overflow/underflow/normal.
// Macro FP_EXC_INF_EN: overflow produces infinity instead of saturating to max finite.
module fp_exc_classify
  import fp_exc_pkg::*;
#(
  parameter int unsigned EW = EW_DEF,
  parameter int unsigned MW = MW_DEF
) (
  input  logic          sign_in,
  input  logic [EW-1:0] exp_in,
  input  logic [MW:0]   man_in,
  output logic          sign_out,
  output logic [EW-1:0] exp_out,
  output logic [MW-1:0] man_out,
  output status_e       status
);

  always_comb begin
    sign_out = sign_in;
    exp_out  = exp_in;
    man_out  = man_in[MW-1:0];
    status   = ST_NORM;
    // Priority: overflow beats zero beats underflow.
    if (&exp_in) begin
      status = ST_OVF;
`ifdef FP_EXC_INF_EN
      exp_out = '1;
      man_out = '0;
`else
      exp_out = {{(EW-1){1'b1}}, 1'b0};
      man_out = '1;
`endif
    end else if (exp_in == '0 && man_in == '0) begin
      status  = ST_ZERO;
      exp_out = '0;
      man_out = '0;
    end else if (exp_in <= EW'(1)) begin
      status = ST_UNF;
    end
  end

endmodule

// File: rtl/fp_exc_check_pipe.sv
// One-stage registered FP exception checker with valid/ready handshake and sticky event counters.
// Macro FP_EXC_INF_EN selects infinity on overflow (passed through to fp_exc_classify).
module fp_exc_check_pipe
  import fp_exc_pkg::*;
#(
  parameter int unsigned EW = EW_DEF,
  parameter int unsigned MW = MW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sign_in,
  input  logic [EW-1:0] exp_in,
  input  logic [MW:0]   man_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sign_out,
  output logic [EW-1:0] exp_out,
  output logic [MW-1:0] man_out,
  output logic [1:0]    status,
  output logic          ovf_sticky,
  output logic          unf_sticky,
  output logic [CW-1:0] ovf_cnt,
  output logic [CW-1:0] unf_cnt,
  input  logic          clr_sticky
);

  logic          cls_sign;
  logic [EW-1:0] cls_exp;
  logic [MW-1:0] cls_man;
  status_e       cls_status;
  status_e       status_q;
  logic          accept;
  logic          ovf_evt;
  logic          unf_evt;

  fp_exc_classify #(
    .EW(EW),
    .MW(MW)
  ) u_classify (
    .sign_in (sign_in),
    .exp_in  (exp_in),
    .man_in  (man_in),
    .sign_out(cls_sign),
    .exp_out (cls_exp),
    .man_out (cls_man),
    .status  (cls_status)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign ovf_evt  = accept && (cls_status == ST_OVF);
  assign unf_evt  = accept && (cls_status == ST_UNF);
  assign status   = status_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sign_out  <= 1'b0;
      exp_out   <= '0;
      man_out   <= '0;
      status_q  <= ST_ZERO;
    end else if (accept) begin
      out_valid <= 1'b1;
      sign_out  <= cls_sign;
      exp_out   <= cls_exp;
      man_out   <= cls_man;
      status_q  <= cls_status;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A clear in the same cycle as an event leaves that event as the first one counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else if (clr_sticky) begin
      ovf_sticky <= ovf_evt;
      ovf_cnt    <= ovf_evt ? CW'(1) : '0;
    end else if (ovf_evt) begin
      ovf_sticky <= 1'b1;
      if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unf_sticky <= 1'b0;
      unf_cnt    <= '0;
    end else if (clr_sticky) begin
      unf_sticky <= unf_evt;
      unf_cnt    <= unf_evt ? CW'(1) : '0;
    end else if (unf_evt) begin
      unf_sticky <= 1'b1;
      if (unf_cnt != '1) unf_cnt <= unf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_exc_check_pipe.sv
// Scoreboard bench for fp_exc_check_pipe: directed corner beats followed by random traffic.
module tb_fp_exc_check_pipe;

  localparam int EW   = 5;
  localparam int MW   = 10;
  localparam int CW   = 2;
  localparam int EMAX = (1 << EW) - 1;
  localparam int MMAX = (1 << MW) - 1;
  localparam int CMAX = (1 << CW) - 1;

`ifdef FP_EXC_INF_EN
  localparam int OVF_E = EMAX;
  localparam int OVF_M = 0;
`else
  localparam int OVF_E = EMAX - 1;
  localparam int OVF_M = MMAX;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          sign_in;
  logic [EW-1:0] exp_in;
  logic [MW:0]   man_in;
  logic          out_valid;
  logic          out_ready;
  logic          sign_out;
  logic [EW-1:0] exp_out;
  logic [MW-1:0] man_out;
  logic [1:0]    status;
  logic          ovf_sticky;
  logic          unf_sticky;
  logic [CW-1:0] ovf_cnt;
  logic [CW-1:0] unf_cnt;
  logic          clr_sticky;

  fp_exc_check_pipe #(
    .EW(EW),
    .MW(MW),
    .CW(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .man_in    (man_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .man_out   (man_out),
    .status    (status),
    .ovf_sticky(ovf_sticky),
    .unf_sticky(unf_sticky),
    .ovf_cnt   (ovf_cnt),
    .unf_cnt   (unf_cnt),
    .clr_sticky(clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s;
    int e;
    int m;
    int st;
  } beat_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    m_ovf_st = 0, m_unf_st = 0, m_ovf_cnt = 0, m_unf_cnt = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic beat_t model(input int s, input int e, input int m);
    beat_t b;
    b.s = s;
    if (e == EMAX) begin
      b.st = 1; b.e = OVF_E; b.m = OVF_M;
    end else if (e == 0 && m == 0) begin
      b.st = 0; b.e = 0; b.m = 0;
    end else if (e <= 1) begin
      b.st = 2; b.e = e; b.m = m % (MMAX + 1);
    end else begin
      b.st = 3; b.e = e; b.m = m % (MMAX + 1);
    end
    return b;
  endfunction

  // Acceptor: decides what the coming rising edge does and updates the reference state.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      beat_t b;
      bit    acc;
      acc = in_valid && (!q.size() || out_ready) ;
      acc = in_valid && in_ready;
      if (clr_sticky) begin
        m_ovf_st = 0; m_unf_st = 0; m_ovf_cnt = 0; m_unf_cnt = 0;
      end
      if (acc) begin
        b = model(int'(sign_in), int'(exp_in), int'(man_in));
        q.push_back(b);
        if (b.st == 1) begin
          m_ovf_st = 1;
          if (m_ovf_cnt < CMAX) m_ovf_cnt++;
        end
        if (b.st == 2) begin
          m_unf_st = 1;
          if (m_unf_cnt < CMAX) m_unf_cnt++;
        end
      end
    end
  end

  // Monitor: compares presented outputs and flags against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", int'(out_valid), 0);
    end else begin
      chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          chk("sign_out", int'(sign_out), q[0].s);
          chk("exp_out", int'(exp_out), q[0].e);
          chk("man_out", int'(man_out), q[0].m);
          chk("status", int'(status), q[0].st);
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk("pending_beats", q.size(), 0);
      end
      chk("ovf_sticky", int'(ovf_sticky), m_ovf_st);
      chk("unf_sticky", int'(unf_sticky), m_unf_st);
      chk("ovf_cnt", int'(ovf_cnt), m_ovf_cnt);
      chk("unf_cnt", int'(unf_cnt), m_unf_cnt);
    end
  end

  task automatic cyc(input bit v, input bit s, input int e, input int m, input bit r, input bit c);
    @(posedge clk);
    #1;
    in_valid   = v;
    sign_in    = s;
    exp_in     = EW'(e);
    man_in     = (MW + 1)'(m);
    out_ready  = r;
    clr_sticky = c;
  endtask

  task automatic idle(input bit r);
    cyc(1'b0, 1'b0, 0, 0, r, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_sign_out"}, int'(sign_out), 0);
    chk({tag, "_exp_out"}, int'(exp_out), 0);
    chk({tag, "_man_out"}, int'(man_out), 0);
    chk({tag, "_status"}, int'(status), 0);
    chk({tag, "_sticky"}, int'({ovf_sticky, unf_sticky}), 0);
    chk({tag, "_cnt"}, int'({ovf_cnt, unf_cnt}), 0);
  endtask

  initial begin
    int e, m;
    rst_n = 1'b0;
    in_valid = 1'b0; sign_in = 1'b0; exp_in = '0; man_in = '0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("init");
    rst_n = 1'b1;

    // Overflow beat
    cyc(1'b1, 1'b1, EMAX, 'h7FF, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("d_ovf_exp", int'(exp_out), OVF_E);
    chk("d_ovf_man", int'(man_out), OVF_M);
    chk("d_ovf_status", int'(status), 1);
    chk("d_ovf_cnt", int'(ovf_cnt), 1);

    // Zero then underflow
    cyc(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1, 'h400, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("d_unf_status", int'(status), 2);
    chk("d_unf_sticky", int'(unf_sticky), 1);
    chk("d_unf_ovf_cnt", int'(ovf_cnt), 1);

    // Backpressure hold
    cyc(1'b1, 1'b0, 15, 'h5A5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, EMAX, 'h7FF, 1'b0, 1'b0);
      @(negedge clk);
      chk("d_hold_in_ready", int'(in_ready), 0);
      chk("d_hold_man", int'(man_out), 'h1A5);
    end
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("d_hold_consumed", int'(out_valid), 0);
    chk("d_hold_ovf_cnt", int'(ovf_cnt), 1);

    // Counter saturation
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, EMAX, i, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("d_sat_ovf_cnt", int'(ovf_cnt), CMAX);

    // Clear coincident with an overflow event
    cyc(1'b1, 1'b0, EMAX, 0, 1'b1, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("d_clr_ovf_sticky", int'(ovf_sticky), 1);
    chk("d_clr_ovf_cnt", int'(ovf_cnt), 1);
    chk("d_clr_unf_cnt", int'(unf_cnt), 0);

    // Reset while a beat is held
    cyc(1'b1, 1'b0, 20, 'h123, 1'b0, 1'b0);
    idle(1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid");
    q.delete();
    m_ovf_st = 0; m_unf_st = 0; m_ovf_cnt = 0; m_unf_cnt = 0;
    cyc(1'b1, 1'b1, 2, 'h3FF, 1'b1, 1'b0);
    rst_n = 1'b1;
    idle(1'b1);
    @(negedge clk);
    chk("d_post_rst_valid", int'(out_valid), 1);
    chk("d_post_rst_exp", int'(exp_out), 2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: e = 0;
        1: e = 1;
        2: e = EMAX;
        default: e = int'($urandom_range(0, EMAX));
      endcase
      m = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, (1 << (MW + 1)) - 1));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, e, m,
          $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
    end

    repeat (4) idle(1'b1);
    @(negedge clk);
    #2;
    chk("drain_queue", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_exc_check_pipe.md
FP_EXC_CHECK_PIPE -- requirements
Module: fp_exc_check_pipe

Interface
REQ-001 SHALL have parameter EW, default 5: result exponent width.
REQ-002 SHALL have parameter MW, default 10: stored mantissa width (hidden bit excluded).
REQ-003 SHALL have parameter CW, default 8: event counter width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 sign_in  input  1  result sign.
REQ-009 exp_in  input  EW  unchecked result exponent.
REQ-010 man_in  input  MW+1  unchecked mantissa including hidden bit.
REQ-011 out_valid  output  1  registered result present.
REQ-012 out_ready  input  1  downstream accepts output.
REQ-013 sign_out  output  1  checked sign.
REQ-014 exp_out  output  EW  checked exponent.
REQ-015 man_out  output  MW  checked mantissa, hidden bit dropped.
REQ-016 status  output  2  00 zero, 01 overflow, 10 underflow, 11 normal.
REQ-017 ovf_sticky, unf_sticky  output  1 each  sticky exception flags.
REQ-018 ovf_cnt, unf_cnt  output  CW each  saturating event counters.
REQ-019 clr_sticky  input  1  synchronous clear of sticky flags and counters.

Function
REQ-020 Classification, priority order: exp_in all-ones -> overflow; exp_in==0 and man_in==0 -> zero; exp_in<=1 -> underflow; else normal.
REQ-021 Overflow without FP_EXC_INF_EN SHALL emit exp_out=all-ones-minus-1, man_out=all ones (max finite).
REQ-022 Zero SHALL emit exp_out=0, man_out=0, sign passed through.
REQ-023 Underflow and normal SHALL emit exp_out=exp_in, man_out=man_in[MW-1:0].
REQ-024 sign_out SHALL equal sign_in in every class.
REQ-025 in_ready SHALL equal !out_valid || out_ready (combinational, no bubble).
REQ-026 Accept = in_valid && in_ready; accepted beat SHALL appear on outputs with out_valid=1 the next cycle (latency 1).
REQ-027 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-028 out_valid SHALL clear after out_ready when no new beat accepted same cycle.
REQ-029 On accept of overflow beat, ovf_sticky SHALL set and ovf_cnt SHALL increment, saturating at 2^CW-1; same for underflow with unf_*.
REQ-030 clr_sticky SHALL zero flags and counters; clr_sticky coincident with an accepted event SHALL leave flag=1, counter=1.
REQ-031 Non-accepted input SHALL affect no state.

Reset
REQ-032 While rst_n=0: out_valid=0, sign_out=0, exp_out=0, man_out=0, status=00, sticky flags 0, counters 0.
REQ-033 Reset mid-handshake SHALL discard the held beat; first accept after release behaves as REQ-026.

Configuration
REQ-034 Macro FP_EXC_INF_EN defined: overflow SHALL emit exp_out=all-ones, man_out=0 (infinity); undefined: saturate per REQ-021; classification, status and counting identical either way.

Structure
REQ-035 Package fp_exc_pkg SHALL hold the status encoding constants (ST_ZERO, ST_OVF, ST_UNF, ST_NORM) and default EW/MW/CW.
REQ-036 Combinational sub-module fp_exc_classify SHALL implement REQ-020..024; top holds pipeline register, handshake, flags, counters.

Verification
REQ-037 exp_in=31, man_in=11'h7FF, sign 1 -> next cycle status=01, exp_out=30, man_out=10'h3FF, ovf_cnt=1 (INF_EN: exp_out=31, man_out=0).
REQ-038 exp_in=0, man_in=0 -> status=00, outputs zero, counters unchanged; exp_in=1, man_in=11'h400 -> status=10, unf_sticky=1.
REQ-039 exp_in=15, man_in=11'h5A5, out_ready=0 for 3 cycles -> in_ready=0, outputs held, no extra count; out_ready=1 -> beat consumed.
REQ-040 CW=2, five overflow beats -> ovf_cnt stops at 3.
REQ-041 clr_sticky with accepted overflow same cycle -> ovf_sticky=1, ovf_cnt=1.
REQ-042 rst_n low while out_valid=1 -> out_valid=0 immediately, all outputs per REQ-032.
